// File: rtl/player_input_control_pkg.sv
// rtl/player_input_control_pkg.sv - shared types, tile ids and FSM encoding for player input control
package player_input_control_pkg;

  typedef logic [1:0] tile_t;

  localparam tile_t TILE_TL = 2'd0;
  localparam tile_t TILE_TR = 2'd1;
  localparam tile_t TILE_BL = 2'd2;
  localparam tile_t TILE_BR = 2'd3;

  localparam logic [4:0] DIFF_EASY = 5'd3;
  localparam logic [4:0] DIFF_MED  = 5'd6;
  localparam logic [4:0] DIFF_HARD = 5'd9;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_KEY,
    S_LATCH,
    S_CHECK,
    S_LOAD_FLASH,
    S_DRAW_FLASH,
    S_HOLD,
    S_LOAD_RESTORE,
    S_DRAW_RESTORE,
    S_WAIT_RELEASE,
    S_NEXT,
    S_WIN,
    S_LOSE
  } state_t;

  // One-hot press vector to tile id; callers guarantee exactly one bit is set.
  function automatic tile_t key_to_tile(input logic [3:0] onehot);
    tile_t t;
    t = TILE_TL;
    if (onehot[1]) t = TILE_TR;
    if (onehot[2]) t = TILE_BL;
    if (onehot[3]) t = TILE_BR;
    return t;
  endfunction

endpackage

// File: rtl/player_input_control_if.sv
// rtl/player_input_control_if.sv - sequence-store read port and tile-draw datapath controls
interface player_input_control_if;
  import player_input_control_pkg::*;

  logic [4:0] seq_index;
  tile_t      seq_tile;
  tile_t      tile_num;
  logic       ld_tile;
  logic       ld_flash;
  logic       ld_previous;
  logic       writeEnable;
  logic       counterEnable;

  modport master (
    output seq_index, tile_num, ld_tile, ld_flash, ld_previous, writeEnable, counterEnable,
    input  seq_tile
  );

  modport slave (
    input  seq_index, tile_num, ld_tile, ld_flash, ld_previous, writeEnable, counterEnable,
    output seq_tile
  );
endinterface

// File: rtl/player_input_control_key_sync.sv
// rtl/player_input_control_key_sync.sv - key synchronizer with single-key press edge detect
module player_input_control_key_sync (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] key_n,
  output logic [3:0] keys_s,
  output logic [3:0] press_edge
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;
  logic [3:0] prev_q, prev_d;

  // Two-flop synchronizer chain plus one previous-sample stage for edge detection.
  always_comb begin
    meta_d = key_n;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Released keys read high, so everything resets to 1 to avoid phantom presses.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
      prev_q <= 4'hF;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // A press counts only when exactly one key is low and that key was high last cycle.
  always_comb begin
    press_edge = 4'b0000;
    case (sync_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: press_edge = ~sync_q & prev_q;
      default:                            press_edge = 4'b0000;
    endcase
  end

  assign keys_s = sync_q;

endmodule

// File: rtl/player_input_control.sv
// rtl/player_input_control.sv - reads player key presses, checks them against the sequence, flashes tiles
module player_input_control
  import player_input_control_pkg::*;
#(
  parameter int TILE_PIXELS    = 64,
  parameter int HOLD_CYCLES    = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [4:0]                    difficulty,
  input  logic [3:0]                    key_n,
  player_input_control_if.master        bus,
  output logic                          busy,
  output logic                          round_win,
  output logic                          round_lose
);

  localparam logic [6:0]  PIX_LAST  = 7'(TILE_PIXELS - 1);
  localparam logic [27:0] HOLD_LAST = 28'(HOLD_CYCLES - 1);
  localparam logic [27:0] TOUT_LAST = 28'(TIMEOUT_CYCLES - 1);

  logic [3:0] keys_s;
  logic [3:0] press_edge;

  player_input_control_key_sync u_key_sync (
    .clock      (clock),
    .resetn     (resetn),
    .key_n      (key_n),
    .keys_s     (keys_s),
    .press_edge (press_edge)
  );

  state_t      state_q, state_d;
  logic [4:0]  seq_index_q, seq_index_d;
  logic [4:0]  diff_q, diff_d;
  tile_t       pressed_q, pressed_d;
  logic [6:0]  pix_q, pix_d;
  logic [27:0] hold_q, hold_d;
  logic [27:0] tout_q, tout_d;

  tile_t tile_num;
  logic  ld_tile, ld_flash, ld_previous, write_en, counter_en, win, lose;

  // State and counter registers; reset abandons any tile draw in progress.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      seq_index_q <= 5'd0;
      diff_q      <= 5'd0;
      pressed_q   <= TILE_TL;
      pix_q       <= 7'd0;
      hold_q      <= 28'd0;
      tout_q      <= 28'd0;
    end else begin
      state_q     <= state_d;
      seq_index_q <= seq_index_d;
      diff_q      <= diff_d;
      pressed_q   <= pressed_d;
      pix_q       <= pix_d;
      hold_q      <= hold_d;
      tout_q      <= tout_d;
    end
  end

  // Next-state, counter updates and Moore outputs for one round of player input.
  always_comb begin
    state_d     = state_q;
    seq_index_d = seq_index_q;
    diff_d      = diff_q;
    pressed_d   = pressed_q;
    pix_d       = pix_q;
    hold_d      = hold_q;
    tout_d      = tout_q;
    tile_num    = TILE_TL;
    ld_tile     = 1'b0;
    ld_flash    = 1'b0;
    ld_previous = 1'b0;
    write_en    = 1'b0;
    counter_en  = 1'b0;
    win         = 1'b0;
    lose        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seq_index_d = 5'd0;
          diff_d      = difficulty;
          tout_d      = 28'd0;
          state_d     = (difficulty == 5'd0) ? S_WIN : S_WAIT_KEY;
        end
      end
      S_WAIT_KEY: begin
        // The press edge lasts one cycle, so the tile is captured here on the way to LATCH.
        if (|press_edge) begin
          pressed_d = key_to_tile(press_edge);
          state_d   = S_LATCH;
        end else if (tout_q == TOUT_LAST) begin
          state_d = S_LOSE;
        end else begin
          tout_d = tout_q + 28'd1;
        end
      end
      S_LATCH: state_d = S_CHECK;
      S_CHECK: state_d = (pressed_q != bus.seq_tile) ? S_LOSE : S_LOAD_FLASH;
      S_LOAD_FLASH: begin
        ld_tile  = 1'b1;
        ld_flash = 1'b1;
        tile_num = pressed_q;
        pix_d    = 7'd0;
        state_d  = S_DRAW_FLASH;
      end
      S_DRAW_FLASH: begin
        write_en   = 1'b1;
        counter_en = 1'b1;
        tile_num   = pressed_q;
        if (pix_q == PIX_LAST) begin
          hold_d  = 28'd0;
          state_d = S_HOLD;
        end else begin
          pix_d = pix_q + 7'd1;
        end
      end
      S_HOLD: begin
        tile_num = pressed_q;
        if (hold_q == HOLD_LAST) state_d = S_LOAD_RESTORE;
        else                     hold_d  = hold_q + 28'd1;
      end
      S_LOAD_RESTORE: begin
        ld_previous = 1'b1;
        tile_num    = pressed_q;
        pix_d       = 7'd0;
        state_d     = S_DRAW_RESTORE;
      end
      S_DRAW_RESTORE: begin
        write_en   = 1'b1;
        counter_en = 1'b1;
        tile_num   = pressed_q;
        if (pix_q == PIX_LAST) state_d = S_WAIT_RELEASE;
        else                   pix_d   = pix_q + 7'd1;
      end
      S_WAIT_RELEASE: begin
        if (keys_s == 4'hF) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (seq_index_q == diff_q - 5'd1) begin
          state_d = S_WIN;
        end else begin
          seq_index_d = seq_index_q + 5'd1;
          tout_d      = 28'd0;
          state_d     = S_WAIT_KEY;
        end
      end
      S_WIN: begin
        win     = 1'b1;
        state_d = S_IDLE;
      end
      S_LOSE: begin
        lose    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.seq_index     = seq_index_q;
  assign bus.tile_num      = tile_num;
  assign bus.ld_tile       = ld_tile;
  assign bus.ld_flash      = ld_flash;
  assign bus.ld_previous   = ld_previous;
  assign bus.writeEnable   = write_en;
  assign bus.counterEnable = counter_en;
  assign busy              = (state_q != S_IDLE);
  assign round_win         = win;
  assign round_lose        = lose;

endmodule

// File: tb/tb_player_input_control.sv
// tb/tb_player_input_control.sv - randomized self-checking bench for player_input_control
module tb_player_input_control;

  localparam int HOLD = 4;
  localparam int TOUT = 50;
  localparam int PIX  = 64;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic [4:0] difficulty;
  logic [3:0] key_n;
  logic       busy, round_win, round_lose;

  player_input_control_if bus ();

  player_input_control #(
    .TILE_PIXELS(PIX), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start), .difficulty(difficulty),
    .key_n(key_n), .bus(bus), .busy(busy), .round_win(round_win), .round_lose(round_lose)
  );

  always #5 clock = ~clock;

  // Sequence store with one cycle of read latency.
  logic [1:0] rom [32];
  always @(posedge clock) bus.seq_tile <= rom[bus.seq_index];

  // Observation counters and logs, sampled on the falling edge.
  int cyc = 0;
  int win_cnt = 0, lose_cnt = 0, we_cnt = 0, flash_cnt = 0, prev_cnt = 0, rise_cnt = 0;
  int overlap_bad = 0;
  int last_lose_cyc = 0;
  logic [1:0] flash_log [1024];
  logic [1:0] prev_log [1024];
  int rise_log [1024];
  logic we_last = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    we_last <= bus.writeEnable;
    if (round_win) win_cnt <= win_cnt + 1;
    if (round_lose) begin
      lose_cnt      <= lose_cnt + 1;
      last_lose_cyc <= cyc;
    end
    if (bus.writeEnable) we_cnt <= we_cnt + 1;
    if (bus.writeEnable && !we_last) begin
      rise_log[rise_cnt] <= cyc;
      rise_cnt           <= rise_cnt + 1;
    end
    if (bus.ld_flash && bus.ld_tile) begin
      flash_log[flash_cnt] <= bus.tile_num;
      flash_cnt            <= flash_cnt + 1;
    end
    if (bus.ld_previous) begin
      prev_log[prev_cnt] <= bus.tile_num;
      prev_cnt           <= prev_cnt + 1;
    end
    if ((bus.ld_tile || bus.ld_flash || bus.ld_previous) && bus.writeEnable)
      overlap_bad <= overlap_bad + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int start_cyc;
  task automatic pulse_start(input logic [4:0] d);
    difficulty = d;
    start      = 1'b1;
    start_cyc  = cyc;
    step(1);
    start      = 1'b0;
  endtask

  task automatic press(input logic [1:0] t);
    key_n = 4'hF & ~(4'b0001 << t);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      step(1);
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  logic [1:0] presses [32];
  int first_press_cyc, last_press_cyc;

  // Plays presses[0..diff-1] against rom and checks the round against a direct
  // reading of the game rules: the round stops at the first wrong press.
  task automatic play_round(input string tag, input int diff);
    int  w0, l0, we0, f0, p0, r0, nf, idx;
    bit  win_exp;
    w0 = win_cnt; l0 = lose_cnt; we0 = we_cnt; f0 = flash_cnt; p0 = prev_cnt; r0 = rise_cnt;
    win_exp = 1'b1; nf = 0; idx = 0;
    for (int i = 0; i < diff; i++) begin
      idx = i;
      if (presses[i] != rom[i]) begin
        win_exp = 1'b0;
        break;
      end
      nf++;
    end
    pulse_start(diff[4:0]);
    for (int i = 0; i < diff; i++) begin
      step(3);
      press(presses[i]);
      if (i == 0) first_press_cyc = cyc;
      last_press_cyc = cyc;
      if (presses[i] != rom[i]) begin
        step(12);
        key_n = 4'hF;
        break;
      end
      step(160);
      key_n = 4'hF;
      step(8);
      if (i == 0 && diff > 1) pulse_start(5'd1);
    end
    wait_idle(tag, 300);
    chk({tag, "_win"},   win_cnt - w0,   {31'd0, win_exp});
    chk({tag, "_lose"},  lose_cnt - l0,  {31'd0, ~win_exp});
    chk({tag, "_we"},    we_cnt - we0,   nf * 2 * PIX);
    chk({tag, "_flash"}, flash_cnt - f0, nf);
    chk({tag, "_restore"}, prev_cnt - p0, nf);
    chk({tag, "_idx"},   {27'd0, bus.seq_index}, idx);
    for (int k = 0; k < nf; k++) begin
      chk({tag, "_ftile"}, {30'd0, flash_log[f0 + k]}, {30'd0, rom[k]});
      chk({tag, "_rtile"}, {30'd0, prev_log[p0 + k]},  {30'd0, rom[k]});
    end
    if (nf > 0) chk({tag, "_plot_lat"}, rise_log[r0], first_press_cyc + 2 + 4);
  endtask

  initial begin
    int w0, l0, we0, f0, d, c, a, b;

    for (int i = 0; i < 32; i++) begin
      rom[i]     = 2'd0;
      presses[i] = 2'd0;
    end
    resetn = 1'b0; start = 1'b0; difficulty = 5'd0; key_n = 4'hF;
    step(3);
    chk("rst_busy",  {31'd0, busy}, 0);
    chk("rst_win",   {31'd0, round_win}, 0);
    chk("rst_lose",  {31'd0, round_lose}, 0);
    chk("rst_we",    {31'd0, bus.writeEnable}, 0);
    chk("rst_ce",    {31'd0, bus.counterEnable}, 0);
    chk("rst_ld",    {29'd0, bus.ld_tile, bus.ld_flash, bus.ld_previous}, 0);
    chk("rst_idx",   {27'd0, bus.seq_index}, 0);
    chk("rst_tile",  {30'd0, bus.tile_num}, 0);
    resetn = 1'b1;
    step(2);

    // Full correct sequence.
    rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd3;
    presses[0] = 2'd2; presses[1] = 2'd0; presses[2] = 2'd3;
    play_round("t1", 3);

    // Wrong second press.
    rom[0] = 2'd1; rom[1] = 2'd1; rom[2] = 2'd1;
    presses[0] = 2'd1; presses[1] = 2'd3;
    play_round("t2", 3);
    chk("t2_lose_lat", last_lose_cyc, last_press_cyc + 2 + 3);

    // No press at all: timeout loss.
    l0 = lose_cnt; f0 = flash_cnt;
    pulse_start(5'd3);
    wait_idle("t3", 100);
    chk("t3_lose",     lose_cnt - l0, 1);
    chk("t3_lose_cyc", last_lose_cyc, start_cyc + 1 + TOUT);
    chk("t3_flash",    flash_cnt - f0, 0);

    // Zero-length round wins immediately.
    w0 = win_cnt; f0 = flash_cnt;
    pulse_start(5'd0);
    wait_idle("t_d0", 5);
    chk("t_d0_win",   win_cnt - w0, 1);
    chk("t_d0_flash", flash_cnt - f0, 0);

    // Two keys at once are ignored; a later single correct key is accepted.
    rom[0] = 2'd2;
    w0 = win_cnt; f0 = flash_cnt; we0 = we_cnt;
    pulse_start(5'd1);
    step(3);
    key_n = 4'b1100;
    step(10);
    chk("t4_multi_flash", flash_cnt - f0, 0);
    chk("t4_multi_busy",  {31'd0, busy}, 1);
    key_n = 4'hF;
    step(5);
    press(2'd2);
    step(160);
    key_n = 4'hF;
    wait_idle("t4", 50);
    chk("t4_win",   win_cnt - w0, 1);
    chk("t4_flash", flash_cnt - f0, 1);
    chk("t4_we",    we_cnt - we0, 2 * PIX);

    // Extra key pressed while the first is still held is never accepted.
    a = $urandom_range(0, 3); b = $urandom_range(0, 3);
    c = (a + 1) % 4;
    if (c == b) c = (c + 1) % 4;
    if (c == a) c = (c + 1) % 4;
    rom[0] = a[1:0]; rom[1] = b[1:0];
    w0 = win_cnt; l0 = lose_cnt; f0 = flash_cnt;
    pulse_start(5'd2);
    step(3);
    press(a[1:0]);
    step(160);
    key_n[c] = 1'b0;
    step(10);
    key_n[a] = 1'b1;
    step(10);
    chk("t5_held_flash", flash_cnt - f0, 1);
    chk("t5_held_busy",  {31'd0, busy}, 1);
    key_n = 4'hF;
    step(8);
    press(b[1:0]);
    step(160);
    key_n = 4'hF;
    wait_idle("t5", 50);
    chk("t5_win",   win_cnt - w0, 1);
    chk("t5_lose",  lose_cnt - l0, 0);
    chk("t5_flash", flash_cnt - f0, 2);

    // Reset in the middle of the second flash draw.
    for (int i = 0; i < 3; i++) rom[i] = 2'($urandom_range(0, 3));
    w0 = win_cnt; l0 = lose_cnt; we0 = we_cnt;
    pulse_start(5'd3);
    step(3);
    press(rom[0]);
    step(160);
    key_n = 4'hF;
    step(8);
    press(rom[1]);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      #1;
      if (we_cnt - we0 >= 2 * PIX + 30) break;
    end
    chk("t6_pre_we",  we_cnt - we0, 2 * PIX + 30);
    chk("t6_pre_idx", {27'd0, bus.seq_index}, 1);
    resetn = 1'b0;
    step(1);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_we",   {31'd0, bus.writeEnable}, 0);
    chk("t6_idx",  {27'd0, bus.seq_index}, 0);
    step(3);
    key_n  = 4'hF;
    resetn = 1'b1;
    step(5);
    chk("t6_we_total", we_cnt - we0, 2 * PIX + 30);
    chk("t6_no_result", (win_cnt - w0) + (lose_cnt - l0), 0);

    // Random rounds, mostly correct presses with occasional mistakes.
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(1, 6);
      for (int i = 0; i < 32; i++) begin
        rom[i]     = 2'($urandom_range(0, 3));
        presses[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : rom[i];
      end
      play_round($sformatf("rnd%0d", r), d);
    end

    chk("no_ld_we_overlap", overlap_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
